// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   Owns the PC and runs a level request / one-cycle done handshake to instruction
//   memory. Each fetched instruction is presented to the hazard stall logic, held
//   while stalled and advanced by 2 when released. A resolved branch/jump redirects
//   the PC, and any fetch already in flight is squashed. HALT stops fetching for good.
//   Slots without a real instruction present NOP_INST.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   stall           hold the presented instruction
//   redirect_valid  taken branch/jump resolved this cycle
//   redirect_pc     redirect target (bit 0 ignored)
//   halt            HALT decoded downstream
//   imem_req        memory request, held until imem_done
//   imem_addr       request address, stable while imem_req
//   imem_rdata      read data, meaningful only with imem_done
//   imem_done       one-cycle completion pulse
//   inst_If         presented instruction (NOP_INST when not valid)
//   pc_If           address of inst_If
//   pc_plus2_If     pc_If + 2, link value
//   inst_valid      inst_If holds a real fetched instruction
//   halted          fetch stopped until reset
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic [15:0] inst_If,
  output logic [15:0] pc_If,
  output logic [15:0] pc_plus2_If,
  output logic        inst_valid,
  output logic        halted
);

  localparam int unsigned XW = 16;
  localparam logic [XW-1:0] PC_STEP = XW'(2);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] pc_q, pc_d;
  logic [XW-1:0] req_addr_q, req_addr_d;
  logic          squash_q, squash_d;
  logic [XW-1:0] inst_d;
  logic [XW-1:0] pc_plus2_d;
  logic          req_d, valid_d, halted_d;
  logic [XW-1:0] redirect_target;
  logic          done_ok;

  // Instruction addresses are halfword aligned.
  assign redirect_target = {redirect_pc[XW-1:1], 1'b0};

  // A done pulse only counts against our own outstanding request; a stray pulse
  // right after reset release (request not yet raised) is dropped.
  assign done_ok = imem_done & imem_req;

  assign pc_If     = pc_q;
  assign imem_addr = req_addr_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      squash_q    <= 1'b0;
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      halted      <= 1'b0;
      inst_If     <= NOP_INST;
      pc_plus2_If <= XW'(RESET_PC + PC_STEP);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      squash_q    <= squash_d;
      imem_req    <= req_d;
      inst_valid  <= valid_d;
      halted      <= halted_d;
      inst_If     <= inst_d;
      pc_plus2_If <= pc_plus2_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    squash_d   = squash_q;
    inst_d     = NOP_INST;
    req_d      = 1'b0;
    valid_d    = 1'b0;
    halted_d   = 1'b0;
    pc_plus2_d = pc_plus2_If;

    unique case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (done_ok) begin
            // Data of the old fetch is dropped; next request goes to the target.
            req_addr_d = redirect_target;
            squash_d   = 1'b0;
          end else begin
            // Old request must complete first; its data will be discarded.
            squash_d = 1'b1;
          end
        end else if (halt) begin
          state_d = done_ok ? S_HALT : S_DRAIN;
        end else if (done_ok) begin
          if (squash_q) begin
            squash_d   = 1'b0;
            req_addr_d = pc_q;
          end else begin
            state_d = S_VALID;
          end
        end
      end

      S_VALID: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          req_addr_d = redirect_target;
          state_d    = S_FETCH;
        end else if (halt) begin
          state_d = S_HALT;
        end else if (!stall) begin
          pc_d       = XW'(pc_q + PC_STEP);
          req_addr_d = XW'(pc_q + PC_STEP);
          state_d    = S_FETCH;
        end
      end

      S_DRAIN: begin
        // Outstanding request must finish before the bus goes idle.
        if (done_ok) begin
          state_d = S_HALT;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Outputs follow the state being entered so they can be registered.
    req_d      = (state_d == S_FETCH) || (state_d == S_DRAIN);
    valid_d    = (state_d == S_VALID);
    halted_d   = (state_d == S_HALT);
    pc_plus2_d = XW'(pc_d + PC_STEP);

    if (state_d == S_VALID) begin
      // Capture memory data on entry; otherwise keep the held instruction.
      inst_d = (state_q == S_VALID) ? inst_If : imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized bench for fetch_unit.
//   A memory responder with configurable latency serves requests from a fixed
//   address->data function. A program-flow model tracks which PC must be presented
//   next and whether a halt is pending, and every cycle's outputs are checked against it.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [15:0] KEY = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_done = 1'b0;
  logic [15:0] inst_If;
  logic [15:0] pc_If;
  logic [15:0] pc_plus2_If;
  logic        inst_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_done(imem_done), .inst_If(inst_If), .pc_If(pc_If),
    .pc_plus2_If(pc_plus2_If), .inst_valid(inst_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          lat_min = 1;
  int          lat_max = 1;
  int          stale_req = 0;
  int          stale_ack = 0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [15:0] cur_addr = 16'h0000;
  logic [15:0] addr_log[$];

  always @(posedge clk) begin
    #1;
    imem_done  = 1'b0;
    imem_rdata = 16'($urandom);
    if (!rst) begin
      busy = 1'b0;
      if (stale_req != stale_ack) begin
        imem_done = 1'b1;
        stale_ack = stale_req;
      end
    end else if (busy) begin
      chk1("req_held", imem_req, 1'b1);
      chk16("addr_stable", imem_addr, cur_addr);
      if (cnt <= 1) begin
        imem_done  = 1'b1;
        imem_rdata = mem_word(cur_addr);
        busy       = 1'b0;
      end else begin
        cnt--;
      end
    end else if (imem_req) begin
      busy     = 1'b1;
      cur_addr = imem_addr;
      cnt      = $urandom_range(lat_max, lat_min);
      addr_log.push_back(imem_addr);
    end
  end

  // ---------------- program-flow model and per-cycle compare ----------------
  logic [15:0] exp_pc = 16'h0000;
  bit          halt_pending = 1'b0;
  int          halt_wait = 0;
  int          idle = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", inst_valid, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk16("rst_inst", inst_If, NOP);
      chk16("rst_pc", pc_If, 16'h0000);
      chk16("rst_addr", imem_addr, 16'h0000);
      chk16("rst_pc2", pc_plus2_If, 16'h0002);
      exp_pc       = 16'h0000;
      halt_pending = 1'b0;
      halt_wait    = 0;
      idle         = 0;
    end else begin
      chk16("pc_plus2", pc_plus2_If, 16'(pc_If + 16'd2));
      if (!inst_valid) chk16("nop_slot", inst_If, NOP);
      if (imem_req) chk1("req_excl", inst_valid | halted, 1'b0);
      if (halted) begin
        chk1("halt_expected", halt_pending, 1'b1);
        chk1("halted_valid", inst_valid, 1'b0);
        chk1("halted_req", imem_req, 1'b0);
      end else if (inst_valid) begin
        chk1("valid_after_halt", halt_pending, 1'b0);
        chk16("pc_If", pc_If, exp_pc);
        chk16("inst_If", inst_If, mem_word(exp_pc));
        idle = 0;
        if (redirect_valid) exp_pc = {redirect_pc[15:1], 1'b0};
        else if (halt) begin
          halt_pending = 1'b1;
          halt_wait    = 0;
        end else if (!stall) exp_pc = 16'(exp_pc + 16'd2);
      end else if (halt_pending) begin
        halt_wait++;
        if (halt_wait > 8) begin
          checks++;
          errors++;
          $display("FAIL halt_timeout waited=%0d required<=8", halt_wait);
          halt_wait = 0;
        end
      end else begin
        idle++;
        if (idle > 80) begin
          checks++;
          errors++;
          $display("FAIL progress_timeout idle=%0d required<=80", idle);
          idle = 0;
        end
        if (redirect_valid) exp_pc = {redirect_pc[15:1], 1'b0};
        else if (halt) begin
          halt_pending = 1'b1;
          halt_wait    = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    halt = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!inst_valid && n < budget) begin
      cyc(1);
      n++;
    end
    chk1("wait_valid", inst_valid, 1'b1);
  endtask

  int base;

  initial begin
    #1 rst = 1'b0;
    lat_min = 1;
    lat_max = 1;
    cyc(2);
    base = addr_log.size();
    rst = 1'b1;

    // Straight-line fetch with 1-cycle memory.
    cyc(3);
    chk1("d1_valid0", inst_valid, 1'b1);
    chk16("d1_inst0", inst_If, 16'hA5C3);
    chk16("d1_pc0", pc_If, 16'h0000);
    cyc(3);
    chk16("d1_inst1", inst_If, 16'hA5C1);
    chk16("d1_pc1", pc_If, 16'h0002);
    chk16("d1_pc2_1", pc_plus2_If, 16'h0004);
    cyc(3);
    chk16("d1_inst2", inst_If, 16'hA5C7);
    chk16("d1_pc2", pc_If, 16'h0004);
    chk16("d1_nlog", 16'(addr_log.size() - base), 16'd3);
    if (addr_log.size() - base >= 3) begin
      chk16("d1_addr0", addr_log[base], 16'h0000);
      chk16("d1_addr1", addr_log[base+1], 16'h0002);
      chk16("d1_addr2", addr_log[base+2], 16'h0004);
    end

    // Stall held for 3 cycles in VALID.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk16("d2_inst_hold", inst_If, 16'hA5C7);
      chk16("d2_pc_hold", pc_If, 16'h0004);
      chk1("d2_req_idle", imem_req, 1'b0);
      cyc(1);
    end
    chk1("d2_still_valid", inst_valid, 1'b1);
    stall = 1'b0;
    lat_min = 3;
    lat_max = 3;
    cyc(1);
    chk1("d2_resume_req", imem_req, 1'b1);
    chk16("d2_resume_addr", imem_addr, 16'h0006);

    // Redirect to 0x0040 while the 0x0006 fetch is outstanding.
    redirect_valid = 1'b1;
    redirect_pc = 16'h0041;
    cyc(1);
    clear_inputs();
    chk1("d3_req_held", imem_req, 1'b1);
    chk16("d3_addr_held", imem_addr, 16'h0006);
    wait_valid(30);
    chk16("d3_pc", pc_If, 16'h0040);
    chk16("d3_inst", inst_If, 16'hA583);
    if (addr_log.size() >= 2) begin
      chk16("d3_prev_addr", addr_log[addr_log.size()-2], 16'h0006);
      chk16("d3_next_addr", addr_log[addr_log.size()-1], 16'h0040);
    end

    // Redirect and halt together in VALID: redirect wins.
    lat_min = 1;
    lat_max = 1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    halt = 1'b1;
    cyc(1);
    clear_inputs();
    chk1("d4_not_halted", halted, 1'b0);
    chk1("d4_req", imem_req, 1'b1);
    chk16("d4_addr", imem_addr, 16'h0100);
    wait_valid(20);
    chk16("d4_pc", pc_If, 16'h0100);
    chk16("d4_inst", inst_If, 16'hA4C3);

    // Halt in FETCH before done: request drains, then halted.
    lat_min = 3;
    lat_max = 3;
    cyc(1);
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    chk1("d5_drain_req", imem_req, 1'b1);
    chk1("d5_drain_nohalt", halted, 1'b0);
    chk16("d5_drain_addr", imem_addr, 16'h0102);
    for (int i = 0; i < 10 && !halted; i++) cyc(1);
    chk1("d5_halted", halted, 1'b1);
    chk1("d5_req_low", imem_req, 1'b0);
    chk16("d5_nop", inst_If, 16'h0800);
    chk1("d5_invalid", inst_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    cyc(1);
    clear_inputs();
    cyc(1);
    chk1("d5_stay_halted", halted, 1'b1);
    chk1("d5_stay_idle", imem_req, 1'b0);

    // Reset mid-request drops the request at once; a stale done after release is ignored.
    lat_min = 1;
    lat_max = 1;
    do_reset();
    wait_valid(10);
    lat_min = 3;
    lat_max = 3;
    cyc(1);
    chk1("d6_req_pending", imem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk1("d6_req_drop", imem_req, 1'b0);
    cyc(1);
    stale_req++;
    lat_min = 1;
    lat_max = 1;
    cyc(1);
    rst = 1'b1;
    wait_valid(10);
    chk16("d6_pc", pc_If, 16'h0000);
    chk16("d6_inst", inst_If, 16'hA5C3);

    // PC wrap at 0xFFFE.
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    cyc(1);
    clear_inputs();
    wait_valid(10);
    chk16("d7_pc", pc_If, 16'hFFFE);
    chk16("d7_pc2", pc_plus2_If, 16'h0000);
    chk16("d7_inst", inst_If, 16'h5A3D);
    cyc(1);
    chk1("d7_req", imem_req, 1'b1);
    chk16("d7_addr", imem_addr, 16'h0000);

    // Randomized segments.
    for (int seg = 0; seg < 8; seg++) begin
      lat_min = 1;
      lat_max = $urandom_range(3, 1);
      do_reset();
      for (int c = 0; c < 500; c++) begin
        int pick;
        stall = ($urandom_range(2, 0) == 0);
        redirect_valid = ($urandom_range(9, 0) == 0);
        pick = $urandom_range(7, 0);
        if (pick == 0) redirect_pc = 16'hFFFE;
        else if (pick == 1) redirect_pc = 16'hFFFF;
        else redirect_pc = 16'($urandom);
        halt = ($urandom_range(299, 0) == 0);
        cyc(1);
      end
      clear_inputs();
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
